// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Two-requester arbiter and access controller in front of the single-port
//   data memory. Requester 0 is the core load/store stage and requester 1 is
//   the debug/DMA loader. One access is granted per cycle. Arbitration is
//   round-robin, and a requester can lock ownership for up to MAX_LOCK
//   consecutive grants. Each granted access is checked for func3 legality and
//   alignment. Legal accesses drive the memory. Every granted access gets a
//   registered one-cycle response pulse in the following cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_mN_req            request valid (N = 0,1)
//   i_mN_lock           keep ownership for the next access
//   i_mN_rd_en          load request
//   i_mN_wr_en          store request
//   i_mN_func3          RISC-V load/store func3
//   i_mN_addr           byte address
//   i_mN_wdata          store data
//   o_mN_gnt            request accepted this cycle (combinational)
//   o_mN_rsp_valid      response pulse, one cycle after grant
//   o_mN_rdata          load data (0 for stores and errors)
//   o_mN_err            access rejected (qualified by rsp_valid)
//   o_mem_rd_en/wr_en   memory enables, legal granted accesses only
//   o_mem_func3/addr/wdata  granted fields to memory (0 when not enabled)
//   i_mem_rdata         memory read data, combinational from addr/func3
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_m0_req,
    input  logic              i_m0_lock,
    input  logic              i_m0_rd_en,
    input  logic              i_m0_wr_en,
    input  logic [2:0]        i_m0_func3,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_gnt,
    output logic              o_m0_rsp_valid,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_err,

    input  logic              i_m1_req,
    input  logic              i_m1_lock,
    input  logic              i_m1_rd_en,
    input  logic              i_m1_wr_en,
    input  logic [2:0]        i_m1_func3,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_gnt,
    output logic              o_m1_rsp_valid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_err,

    output logic              o_mem_rd_en,
    output logic              o_mem_wr_en,
    output logic [2:0]        o_mem_func3,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic {
        ARB   = 1'b0,
        LOCKN = 1'b1
    } ArbState;

    localparam logic [4:0] MAX_LOCK_W = 5'(MAX_LOCK);

    ArbState     r_state;
    ArbState     w_nextState;
    logic        r_lockOwner;
    logic        w_nextLockOwner;
    logic [3:0]  r_lockCnt;
    logic [3:0]  w_nextLockCnt;
    logic        r_rrPtr;
    logic        w_nextRrPtr;

    logic        w_ownerReq;
    logic        w_holdOwner;
    logic        w_anyGnt;
    logic        w_sel;
    logic [4:0]  w_cntPlus;

    logic        w_selLock;
    logic        w_selRd;
    logic        w_selWr;
    logic [2:0]  w_selFunc3;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selWdata;
    logic        w_fieldOk;
    logic        w_legal;
    logic        w_accessOk;

    logic        r_rspValid0;
    logic        r_rspValid1;
    logic        r_err;
    logic [DATA_W-1:0] r_rdata;

    // Grant selection. While locked, the owner wins whenever it requests.
    // Otherwise (plain ARB, or a locked cycle where the owner went idle) the
    // round-robin pointer breaks ties. No grant is given while in reset.
    always_comb begin
        w_ownerReq  = r_lockOwner ? i_m1_req : i_m0_req;
        w_holdOwner = (r_state == LOCKN) && w_ownerReq;
        w_anyGnt    = 1'b0;
        w_sel       = 1'b0;
        if (!rst) begin
            if (w_holdOwner) begin
                w_anyGnt = 1'b1;
                w_sel    = r_lockOwner;
            end else if (i_m0_req && i_m1_req) begin
                w_anyGnt = 1'b1;
                w_sel    = r_rrPtr;
            end else if (i_m0_req) begin
                w_anyGnt = 1'b1;
                w_sel    = 1'b0;
            end else if (i_m1_req) begin
                w_anyGnt = 1'b1;
                w_sel    = 1'b1;
            end
        end
    end

    assign o_m0_gnt = w_anyGnt & ~w_sel;
    assign o_m1_gnt = w_anyGnt &  w_sel;

    // Mux the granted requester's fields onto one set of wires.
    assign w_selLock  = w_sel ? i_m1_lock  : i_m0_lock;
    assign w_selRd    = w_sel ? i_m1_rd_en : i_m0_rd_en;
    assign w_selWr    = w_sel ? i_m1_wr_en : i_m0_wr_en;
    assign w_selFunc3 = w_sel ? i_m1_func3 : i_m0_func3;
    assign w_selAddr  = w_sel ? i_m1_addr  : i_m0_addr;
    assign w_selWdata = w_sel ? i_m1_wdata : i_m0_wdata;
    assign w_cntPlus  = {1'b0, r_lockCnt} + 5'd1;

    // Next-state logic. A locked owner that keeps being granted counts its
    // grants and falls back to ARB when it drops lock or hits the limit.
    // If the owner goes idle the lock is released and the cycle is arbitrated
    // normally, so the other requester's grant decides the final pointer.
    always_comb begin
        w_nextState     = r_state;
        w_nextLockOwner = r_lockOwner;
        w_nextLockCnt   = r_lockCnt;
        w_nextRrPtr     = r_rrPtr;
        if (w_holdOwner) begin
            w_nextLockCnt = w_cntPlus[3:0];
            if (!w_selLock || (w_cntPlus >= MAX_LOCK_W)) begin
                w_nextState = ARB;
                w_nextRrPtr = ~r_lockOwner;
            end
        end else begin
            if (r_state == LOCKN) begin
                w_nextState = ARB;
                w_nextRrPtr = ~r_lockOwner;
            end
            if (w_anyGnt) begin
                w_nextRrPtr = ~w_sel;
                if (w_selLock && (MAX_LOCK > 1)) begin
                    w_nextState     = LOCKN;
                    w_nextLockOwner = w_sel;
                    w_nextLockCnt   = 4'd1;
                end
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB;
            r_lockOwner <= 1'b0;
            r_lockCnt   <= 4'd0;
            r_rrPtr     <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_lockOwner <= w_nextLockOwner;
            r_lockCnt   <= w_nextLockCnt;
            r_rrPtr     <= w_nextRrPtr;
        end
    end

    // Legality check. The encodings 100/101 (unsigned byte/half) exist only
    // for loads. The required alignment follows from the access size.
    always_comb begin
        w_fieldOk = 1'b0;
        case (w_selFunc3)
            3'b000:  w_fieldOk = 1'b1;
            3'b001:  w_fieldOk = ~w_selAddr[0];
            3'b010:  w_fieldOk = (w_selAddr[1:0] == 2'b00);
            3'b100:  w_fieldOk = w_selRd;
            3'b101:  w_fieldOk = w_selRd & ~w_selAddr[0];
            default: w_fieldOk = 1'b0;
        endcase
    end

    assign w_legal    = (w_selRd ^ w_selWr) & w_fieldOk;
    assign w_accessOk = w_anyGnt & w_legal;

    // Rejected accesses are consumed but never reach the memory, and the
    // bus is held at zero whenever nothing legal is in flight.
    assign o_mem_rd_en = w_accessOk & w_selRd;
    assign o_mem_wr_en = w_accessOk & w_selWr;
    assign o_mem_func3 = w_accessOk ? w_selFunc3 : 3'b000;
    assign o_mem_addr  = w_accessOk ? w_selAddr  : '0;
    assign o_mem_wdata = w_accessOk ? w_selWdata : '0;

    // Response registers: capture the outcome of this cycle's grant for
    // delivery in the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rspValid0 <= 1'b0;
            r_rspValid1 <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rspValid0 <= o_m0_gnt;
            r_rspValid1 <= o_m1_gnt;
            r_err       <= w_anyGnt & ~w_legal;
            r_rdata     <= (w_accessOk && w_selRd) ? i_mem_rdata : '0;
        end
    end

    // A response still registered when reset arrives must never show, so the
    // pulse is masked by reset as well as cleared by it.
    assign o_m0_rsp_valid = r_rspValid0 & ~rst;
    assign o_m1_rsp_valid = r_rspValid1 & ~rst;
    assign o_m0_rdata     = o_m0_rsp_valid ? r_rdata : '0;
    assign o_m1_rdata     = o_m1_rsp_valid ? r_rdata : '0;
    assign o_m0_err       = o_m0_rsp_valid & r_err;
    assign o_m1_err       = o_m1_rsp_valid & r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Purpose:
//   Self-checking bench for dmem_arbiter. It contains a byte-array memory
//   device that the DUT drives. A behavioural model predicts grants, the
//   memory bus, and responses from the arbitration and legality rules,
//   working on a separate reference byte array. Directed scenarios run
//   first, followed by randomized traffic from both requesters.
//
// Ports: none (top-level testbench).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MAX_LOCK = 4;
    localparam int MEM_BYTES = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  rdEn;
    logic [1:0]  wrEn;
    logic [2:0]  f3    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];

    logic        m0Gnt, m0RspValid, m0Err;
    logic        m1Gnt, m1RspValid, m1Err;
    logic [31:0] m0Rdata, m1Rdata;
    logic        memRdEn, memWrEn;
    logic [2:0]  memFunc3;
    logic [31:0] memAddr, memWdata, memRdata;

    logic [7:0]  devMem [MEM_BYTES];
    logic [7:0]  refMem [MEM_BYTES];

    int nChecks = 0;
    int nMiscompares = 0;

    // Behavioural model state
    int          mPtr;
    int          mOwner;
    int          mCnt;
    bit          mLocked;
    bit          expRsp [2];
    logic [31:0] expRdata;
    bit          expErr;
    int          lastGnt;

    // Observations from the most recent cycle, for scenario checks
    logic        obsGnt0, obsGnt1, obsRv0, obsErr0, obsMemRd, obsMemWr;
    logic [31:0] obsRdata0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_m0_req       (req[0]),
        .i_m0_lock      (lock[0]),
        .i_m0_rd_en     (rdEn[0]),
        .i_m0_wr_en     (wrEn[0]),
        .i_m0_func3     (f3[0]),
        .i_m0_addr      (addr[0]),
        .i_m0_wdata     (wdata[0]),
        .o_m0_gnt       (m0Gnt),
        .o_m0_rsp_valid (m0RspValid),
        .o_m0_rdata     (m0Rdata),
        .o_m0_err       (m0Err),
        .i_m1_req       (req[1]),
        .i_m1_lock      (lock[1]),
        .i_m1_rd_en     (rdEn[1]),
        .i_m1_wr_en     (wrEn[1]),
        .i_m1_func3     (f3[1]),
        .i_m1_addr      (addr[1]),
        .i_m1_wdata     (wdata[1]),
        .o_m1_gnt       (m1Gnt),
        .o_m1_rsp_valid (m1RspValid),
        .o_m1_rdata     (m1Rdata),
        .o_m1_err       (m1Err),
        .o_mem_rd_en    (memRdEn),
        .o_mem_wr_en    (memWrEn),
        .o_mem_func3    (memFunc3),
        .o_mem_addr     (memAddr),
        .o_mem_wdata    (memWdata),
        .i_mem_rdata    (memRdata)
    );

    // Load formatting: pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] loadValue(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] fn);
        logic [31:0] sh;
        sh = word >> (8 * off);
        case (fn)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            3'b010:  return word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] devWord(input logic [31:0] a);
        int b;
        b = int'(a) & (MEM_BYTES - 4);
        return {devMem[b+3], devMem[b+2], devMem[b+1], devMem[b]};
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] a);
        int b;
        b = int'(a) & (MEM_BYTES - 4);
        return {refMem[b+3], refMem[b+2], refMem[b+1], refMem[b]};
    endfunction

    function automatic int accessBytes(input logic [2:0] fn);
        case (fn)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Reference legality: exactly one of load/store, a known size, the
    // unsigned forms only for loads, and the address a multiple of the size.
    function automatic bit isLegal(input logic rd, input logic wr, input logic [2:0] fn,
                                   input logic [31:0] a);
        int sz;
        sz = accessBytes(fn);
        if (rd == wr) return 1'b0;
        if (sz == 0) return 1'b0;
        if (wr && fn[2]) return 1'b0;
        return (int'(a[3:0]) % sz) == 0;
    endfunction

    assign memRdata = loadValue(devWord(memAddr), memAddr[1:0], memFunc3);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setWord(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            devMem[a+k] = w[8*k +: 8];
            refMem[a+k] = w[8*k +: 8];
        end
    endtask

    task automatic setReq(input int i, input logic r, input logic lk, input logic rd,
                          input logic wr, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] d);
        req[i]   = r;
        lock[i]  = lk;
        rdEn[i]  = rd;
        wrEn[i]  = wr;
        f3[i]    = fn;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    // One clock cycle: inputs are already set. Check everything at the
    // negedge against the model, then advance the model and the memory
    // device across the posedge.
    task automatic applyStimulus();
        int          g;
        bit          legal;
        bit          gi;
        bit          rv0, rv1;
        logic        sWr;
        logic [2:0]  sFn;
        logic [31:0] sAddr, sData;
        logic [31:0] eFn, eAddr, eData;
        int          sz;

        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (mLocked && req[mOwner]) g = mOwner;
            else if (req == 2'b11)      g = mPtr;
            else if (req[0])            g = 0;
            else if (req[1])            g = 1;
        end
        gi    = (g == 1);
        legal = (g >= 0) && isLegal(rdEn[gi], wrEn[gi], f3[gi], addr[gi]);
        rv0   = expRsp[0] && !rst;
        rv1   = expRsp[1] && !rst;
        eFn   = legal ? 32'(f3[gi])  : 32'h0;
        eAddr = legal ? addr[gi]     : 32'h0;
        eData = legal ? wdata[gi]    : 32'h0;

        checkOutput("gnt0",     32'(m0Gnt),      32'(g == 0));
        checkOutput("gnt1",     32'(m1Gnt),      32'(g == 1));
        checkOutput("rsp0",     32'(m0RspValid), 32'(rv0));
        checkOutput("rsp1",     32'(m1RspValid), 32'(rv1));
        checkOutput("rdata0",   m0Rdata,         rv0 ? expRdata : 32'h0);
        checkOutput("rdata1",   m1Rdata,         rv1 ? expRdata : 32'h0);
        checkOutput("err0",     32'(m0Err),      32'(rv0 && expErr));
        checkOutput("err1",     32'(m1Err),      32'(rv1 && expErr));
        checkOutput("mem_rd",   32'(memRdEn),    32'(legal && rdEn[gi]));
        checkOutput("mem_wr",   32'(memWrEn),    32'(legal && wrEn[gi]));
        checkOutput("mem_f3",   32'(memFunc3),   eFn);
        checkOutput("mem_addr", memAddr,         eAddr);
        checkOutput("mem_wd",   memWdata,        eData);

        obsGnt0   = m0Gnt;
        obsGnt1   = m1Gnt;
        obsRv0    = m0RspValid;
        obsErr0   = m0Err;
        obsRdata0 = m0Rdata;
        obsMemRd  = memRdEn;
        obsMemWr  = memWrEn;
        sWr   = memWrEn;
        sFn   = memFunc3;
        sAddr = memAddr;
        sData = memWdata;

        @(posedge clk);
        // memory device commits whatever store the DUT drove
        if (sWr === 1'b1) begin
            sz = accessBytes(sFn);
            for (int k = 0; k < sz; k++)
                devMem[(int'(sAddr[5:0]) + k) % MEM_BYTES] = sData[8*k +: 8];
        end

        if (rst) begin
            mPtr      = 0;
            mOwner    = 0;
            mCnt      = 0;
            mLocked   = 1'b0;
            expRsp[0] = 1'b0;
            expRsp[1] = 1'b0;
            expErr    = 1'b0;
            expRdata  = 32'h0;
        end else begin
            expRsp[0] = (g == 0);
            expRsp[1] = (g == 1);
            expErr    = !legal;
            expRdata  = (legal && rdEn[gi]) ?
                        loadValue(refWord(addr[gi]), addr[gi][1:0], f3[gi]) : 32'h0;
            if (legal && wrEn[gi]) begin
                sz = accessBytes(f3[gi]);
                for (int k = 0; k < sz; k++)
                    refMem[(int'(addr[gi][5:0]) + k) % MEM_BYTES] = wdata[gi][8*k +: 8];
            end
            if (mLocked && req[mOwner]) begin
                mCnt++;
                if (!lock[gi] || mCnt >= MAX_LOCK) begin
                    mLocked = 1'b0;
                    mPtr    = 1 - mOwner;
                end
            end else begin
                if (mLocked) begin
                    mLocked = 1'b0;
                    mPtr    = 1 - mOwner;
                end
                if (g >= 0) begin
                    mPtr = 1 - g;
                    if (lock[gi] && MAX_LOCK > 1) begin
                        mLocked = 1'b1;
                        mOwner  = g;
                        mCnt    = 1;
                    end
                end
            end
        end
        lastGnt = g;
        #1;
    endtask

    task automatic resetCycle();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
    endtask

    task automatic randomRequest(input int i);
        int          kind;
        logic [2:0]  fn;
        logic [31:0] a;
        kind = int'($urandom_range(0, 9));
        if ($urandom_range(0, 4) == 0) fn = 3'($urandom);
        else begin
            case ($urandom_range(0, 4))
                0: fn = 3'b000;
                1: fn = 3'b001;
                2: fn = 3'b010;
                3: fn = 3'b100;
                default: fn = 3'b101;
            endcase
        end
        a = 32'($urandom_range(0, MEM_BYTES - 1));
        if ($urandom_range(0, 9) < 7) begin
            if (fn[1:0] == 2'b01) a[0] = 1'b0;
            if (fn[1:0] == 2'b10) a[1:0] = 2'b00;
        end
        setReq(i, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
               kind < 4 || kind == 8, (kind >= 4 && kind < 8) || kind == 8,
               fn, a, $urandom);
    endtask

    initial begin
        int  m0Wait;
        int  m0MaxWait;
        bit  pending [2];
        logic [31:0] savedWord;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) setReq(i, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < MEM_BYTES; i++) begin
            devMem[i] = 8'($urandom);
            refMem[i] = devMem[i];
        end
        mPtr = 0; mOwner = 0; mCnt = 0; mLocked = 0;
        expRsp[0] = 0; expRsp[1] = 0; expErr = 0; expRdata = 0; lastGnt = -1;

        // reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_gnt0", 32'(obsGnt0), 32'h0);
        checkOutput("rst_rsp0", 32'(obsRv0),  32'h0);
        rst = 1'b0;

        // single LW from m0
        setWord(8, 32'hDEADBEEF);
        setReq(0, 1, 0, 1, 0, 3'b010, 32'h8, 32'h0);
        applyStimulus();
        checkOutput("t1_gnt", 32'(obsGnt0), 32'h1);
        setReq(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
        applyStimulus();
        checkOutput("t1_rsp",   32'(obsRv0),  32'h1);
        checkOutput("t1_rdata", obsRdata0,    32'hDEADBEEF);
        checkOutput("t1_err",   32'(obsErr0), 32'h0);

        // both requesting without lock: strict alternation from m0
        resetCycle();
        setReq(0, 1, 0, 1, 0, 3'b010, 32'h0, 32'h0);
        setReq(1, 1, 0, 1, 0, 3'b010, 32'h4, 32'h0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            checkOutput($sformatf("t2_alt%0d", k), 32'(obsGnt0), 32'((k % 2) == 0));
            if (k > 0) checkOutput($sformatf("t2_rsp%0d", k), 32'(obsRv0), 32'((k % 2) == 1));
        end

        // m1 locking against m0
        resetCycle();
        setReq(0, 1, 0, 1, 0, 3'b010, 32'h0, 32'h0);
        setReq(1, 1, 1, 1, 0, 3'b010, 32'h4, 32'h0);
        m0Wait = 0;
        m0MaxWait = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus();
            if (k >= 1 && k <= 4) checkOutput($sformatf("t3_lock%0d", k), 32'(obsGnt1), 32'h1);
            if (k == 5) checkOutput("t3_m0_back", 32'(obsGnt0), 32'h1);
            if (obsGnt0) m0Wait = 0;
            else begin
                m0Wait++;
                if (m0Wait > m0MaxWait) m0MaxWait = m0Wait;
            end
        end
        checkOutput("t3_m0_wait_le4", 32'(m0MaxWait <= 4), 32'h1);
        setReq(1, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0);

        // misaligned SH and LW
        resetCycle();
        savedWord = refWord(32'h4);
        setReq(0, 1, 0, 0, 1, 3'b001, 32'h5, 32'h0000FFFF);
        applyStimulus();
        checkOutput("t4_sh_wr", 32'(obsMemWr), 32'h0);
        setReq(0, 1, 0, 1, 0, 3'b010, 32'h6, 32'h0);
        applyStimulus();
        checkOutput("t4_lw_rd",    32'(obsMemRd), 32'h0);
        checkOutput("t4_sh_err",   32'(obsErr0),  32'h1);
        setReq(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
        applyStimulus();
        checkOutput("t4_lw_err",   32'(obsErr0),  32'h1);
        checkOutput("t4_lw_rdata", obsRdata0,     32'h0);
        checkOutput("t4_word",     devWord(32'h4), savedWord);

        // SB then LBU read-after-write, then LW of the whole word
        setWord(0, 32'h11223344);
        setReq(0, 1, 0, 0, 1, 3'b000, 32'h1, 32'h000000AB);
        applyStimulus();
        setReq(0, 1, 0, 1, 0, 3'b100, 32'h1, 32'h0);
        applyStimulus();
        setReq(0, 1, 0, 1, 0, 3'b010, 32'h0, 32'h0);
        applyStimulus();
        checkOutput("t5_lbu", obsRdata0, 32'h000000AB);
        setReq(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
        applyStimulus();
        checkOutput("t5_lw", obsRdata0, 32'h1122AB44);

        // reset right after a grant drops the response
        setReq(0, 1, 0, 1, 0, 3'b010, 32'h8, 32'h0);
        setReq(1, 1, 0, 1, 0, 3'b010, 32'h4, 32'h0);
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOutput("t6_no_rsp", 32'(obsRv0),  32'h0);
        checkOutput("t6_no_gnt", 32'(obsGnt1), 32'h0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("t6_m0_first", 32'(obsGnt0), 32'h1);
        checkOutput("t6_rsp_none", 32'(obsRv0),  32'h0);

        // randomized traffic from both requesters
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pending[i]) begin
                    randomRequest(i);
                    pending[i] = req[i];
                end
            end
            applyStimulus();
            if (lastGnt >= 0) pending[lastGnt] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
        $finish;
    end

endmodule
